sm3_msg_expand_ctrl: RTL and testbench
======================================

// Module: sm3_msg_expand_ctrl
// PURPOSE
//   Sequences SM3 message expansion for one 512-bit block.
//   - Accepts W0..W15 serially.
//   - Generates W16..W67 one word per cycle through the shared P1 permutation:
//     P1(X) = X ^ (X<<<15) ^ (X<<<23).
//   - Streams round pairs (Wj, W'j = Wj ^ Wj+4), j = 0..ROUNDS-1, to the compression-function round engine.
// PARAMETERS
//   ROUNDS  64  number of (Wj, W'j) pairs emitted per block; legal range 1..64
// PORTS
//   clk        in   1   clock; all state updates on the rising edge
//   rst        in   1   asynchronous, active-high reset
//   din        in   32  message word; W0 first, big-endian word order
//   din_valid  in   1   din holds a valid word
//   din_ready  out  1   block is accepting message words
//   w_out      out  32  Wj
//   wp_out     out  32  W'j = Wj ^ Wj+4
//   w_idx      out  6   round index j
//   w_valid    out  1   w_out / wp_out / w_idx are valid
//   w_ready    in   1   consumer accepts the current pair
//   busy       out  1   high in LOAD and RUN
//   done       out  1   one-cycle pulse after the last pair is accepted
// BEHAVIOUR
//   Reset (async, rst=1):
//     - state=IDLE; counters=0; window registers=0.
//     - din_ready=0, w_valid=0, busy=0, done=0; w_out/wp_out/w_idx read 0.
//   Window: 16x32 shift register buf[0..15]. In RUN, buf[k] = W(j+k).
//   States and transitions:
//   - IDLE: din_ready=1.
//     - din_valid=1 -> word captured into buf[15], buf shifts down, cnt=1, go to LOAD.
//   - LOAD: din_ready=1; each din_valid&&din_ready shifts din in and increments cnt.
//     - Capture of the 16th word (cnt==15) -> cnt=0, go to RUN.
//     - din_valid low -> holds; no timeout.
//   - RUN: din_ready=0, w_valid=1.
//     - Outputs are combinational from registers: w_out=buf[0], wp_out=buf[0]^buf[4], w_idx=cnt.
//     - Handshake w_valid&&w_ready:
//       - buf shifts down by one.
//       - buf[15] <= P1(buf[0]^buf[7]^(buf[13]<<<15)) ^ (buf[3]<<<7) ^ buf[10]
//         (i.e. W(j+16)); rotates are 32-bit circular.
//       - cnt increments.
//     - Words generated beyond W67 are don't-care and never observed.
//     - Handshake with cnt==ROUNDS-1 -> done=1 for the next cycle, go to IDLE.
//     - w_ready low -> outputs and state hold stable; w_valid never deasserts once asserted in RUN.
//   - busy = (state==LOAD || state==RUN).
//   Latency: first pair valid the cycle after W15 is captured; one pair/cycle at full throughput.
//     Block of 16 loads + 64 rounds = 80 cycles minimum, plus 1 cycle before done.
//   Boundary conditions:
//     - din_valid in RUN is ignored (din_ready=0); no word is consumed.
//     - done cycle is IDLE: din_ready=1, so a new block may start on the cycle done is high.
//     - rst asserted mid-LOAD or mid-RUN aborts immediately to reset values; no done pulse;
//       the partial block is discarded.
//     - cnt width 6 bits; ROUNDS=64 terminates on cnt==63 without wrap.
// TESTING
//   1. "abc" block (W0=0x61626380, W1..W14=0, W15=0x00000018), w_ready=1 ->
//      - j=0: w_out=0x61626380, wp_out=0x61626380.
//      - j=16: w_out=0x9092E200.
//      - j=12: wp_out=0x9092E200.
//      - done at cycle 81 after first din.
//   2. Same block, w_ready toggled pseudo-randomly -> identical 64-pair sequence to scenario 1;
//      outputs stable while w_ready=0.
//   3. din_valid gapped (idle cycle after every word in LOAD) -> same pairs as scenario 1;
//      din_ready=0 throughout RUN; extra words offered in RUN not consumed.
//   4. rst pulsed at j=30 -> all outputs 0 and w_valid=0 immediately; no done;
//      next full block produces correct pairs.
//   5. Back-to-back blocks, second block's W0 presented during the done cycle ->
//      accepted; second block's pairs match a golden C model.
//   6. ROUNDS=20 build -> exactly 20 pairs (w_idx 0..19), done after j=19, return to IDLE.

Source files
------------

// File: rtl/sm3_msg_expand_ctrl.sv
// sm3_msg_expand_ctrl
// Sequences SM3 message expansion for one 512-bit block: loads W0..W15 into a
// 16-word sliding window, then streams (Wj, W'j) round pairs to the compression
// engine. W16 and later words are generated into the window one per accepted pair.
module sm3_msg_expand_ctrl #(
    parameter int ROUNDS = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] din,
    input  logic        din_valid,
    output logic        din_ready,
    output logic [31:0] w_out,
    output logic [31:0] wp_out,
    output logic [5:0]  w_idx,
    output logic        w_valid,
    input  logic        w_ready,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    localparam logic [5:0] LAST_IDX = 6'(ROUNDS - 1);

    state_t      state;
    state_t      state_nxt;
    logic [5:0]  cnt;
    logic [5:0]  cnt_nxt;
    logic        done_q;
    logic        done_nxt;
    logic        shift_in;
    logic        shift_gen;
    logic [31:0] win [16];
    logic [31:0] gen_word;

    function automatic logic [31:0] rotl(input logic [31:0] x, input int unsigned n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [31:0] p1(input logic [31:0] x);
        return x ^ rotl(x, 15) ^ rotl(x, 23);
    endfunction

    // W(j+16) from the current window, where win[k] holds W(j+k)
    always_comb begin
        gen_word = p1(win[0] ^ win[7] ^ rotl(win[13], 15)) ^ rotl(win[3], 7) ^ win[10];
    end

    // Next-state logic: word capture in IDLE/LOAD, pair handshakes in RUN
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        done_nxt  = 1'b0;
        shift_in  = 1'b0;
        shift_gen = 1'b0;
        case (state)
            IDLE: begin
                if (din_valid) begin
                    shift_in  = 1'b1;
                    cnt_nxt   = 6'd1;
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                if (din_valid) begin
                    shift_in = 1'b1;
                    if (cnt == 6'd15) begin
                        cnt_nxt   = 6'd0;
                        state_nxt = RUN;
                    end else begin
                        cnt_nxt = cnt + 6'd1;
                    end
                end
            end
            RUN: begin
                if (w_ready) begin
                    shift_gen = 1'b1;
                    if (cnt == LAST_IDX) begin
                        cnt_nxt   = 6'd0;
                        done_nxt  = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        cnt_nxt = cnt + 6'd1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 6'd0;
            end
        endcase
    end

    // Control registers: state, word/round counter and the done pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= 6'd0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            done_q <= done_nxt;
        end
    end

    // Sliding window: shifts down on every captured or generated word
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 16; k++) begin
                win[k] <= 32'd0;
            end
        end else if (shift_in || shift_gen) begin
            for (int k = 0; k < 15; k++) begin
                win[k] <= win[k + 1];
            end
            win[15] <= shift_in ? din : gen_word;
        end
    end

    // Outputs are decoded from registers; din_ready is held low while reset is applied
    always_comb begin
        din_ready = !rst && (state == IDLE || state == LOAD);
        w_valid   = (state == RUN);
        w_out     = (state == RUN) ? win[0] : 32'd0;
        wp_out    = (state == RUN) ? (win[0] ^ win[4]) : 32'd0;
        w_idx     = (state == RUN) ? cnt : 6'd0;
        busy      = (state == LOAD) || (state == RUN);
        done      = done_q;
    end

endmodule

// File: tb/tb_sm3_msg_expand_ctrl.sv
// tb_sm3_msg_expand_ctrl
// Drives message blocks into two builds of the expansion controller (ROUNDS=64
// and ROUNDS=20) and compares every streamed pair against a reference model that
// computes W0..W67 directly from the SM3 expansion recurrence.
module tb_sm3_msg_expand_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] din;
    logic        din_valid;
    logic        w_ready;

    logic        din_ready, w_valid, busy, done;
    logic [31:0] w_out, wp_out;
    logic [5:0]  w_idx;

    logic        din_ready20, w_valid20, busy20, done20;
    logic [31:0] w_out20, wp_out20;
    logic [5:0]  w_idx20;

    logic        sel20 = 1'b0;

    logic        oDinReady, oWValid, oBusy, oDone;
    logic [31:0] oWOut, oWpOut;
    logic [5:0]  oWIdx;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [31:0] curBlk [16];
    logic [31:0] refW   [68];
    logic [31:0] gotW   [64];
    logic [31:0] gotWp  [64];

    sm3_msg_expand_ctrl #(.ROUNDS(64)) dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready),
        .w_out(w_out), .wp_out(wp_out), .w_idx(w_idx), .w_valid(w_valid),
        .w_ready(w_ready), .busy(busy), .done(done)
    );

    sm3_msg_expand_ctrl #(.ROUNDS(20)) dut20 (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready20),
        .w_out(w_out20), .wp_out(wp_out20), .w_idx(w_idx20), .w_valid(w_valid20),
        .w_ready(w_ready), .busy(busy20), .done(done20)
    );

    assign oDinReady = sel20 ? din_ready20 : din_ready;
    assign oWValid   = sel20 ? w_valid20   : w_valid;
    assign oBusy     = sel20 ? busy20      : busy;
    assign oDone     = sel20 ? done20      : done;
    assign oWOut     = sel20 ? w_out20     : w_out;
    assign oWpOut    = sel20 ? wp_out20    : wp_out;
    assign oWIdx     = sel20 ? w_idx20     : w_idx;

    always #5 clk = ~clk;

    function automatic logic [31:0] rol(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [31:0] p1(input logic [31:0] x);
        return x ^ rol(x, 15) ^ rol(x, 23);
    endfunction

    task automatic computeRef();
        for (int i = 0; i < 16; i++) refW[i] = curBlk[i];
        for (int j = 16; j < 68; j++) begin
            refW[j] = p1(refW[j-16] ^ refW[j-9] ^ rol(refW[j-3], 15)) ^ rol(refW[j-13], 7) ^ refW[j-6];
        end
    endtask

    task automatic setAbc();
        curBlk[0] = 32'h61626380;
        for (int i = 1; i < 15; i++) curBlk[i] = 32'd0;
        curBlk[15] = 32'h00000018;
        computeRef();
    endtask

    task automatic setRandom();
        for (int i = 0; i < 16; i++) curBlk[i] = $urandom;
        computeRef();
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic applyStimulus(input bit gapped);
        w_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            din       = curBlk[i];
            din_valid = 1'b1;
            checkOutput("load_din_ready", 32'(oDinReady), 32'd1);
            checkOutput("load_w_valid", 32'(oWValid), 32'd0);
            step();
            if (gapped && i < 15) begin
                din_valid = 1'b0;
                din       = $urandom;
                step();
                checkOutput("gap_busy", 32'(oBusy), 32'd1);
            end
        end
        din_valid = 1'b0;
    endtask

    task automatic drainPairs(input int n, input bit randReady, input bit offerDin, output int endCyc);
        int j;
        int guard;
        j     = 0;
        guard = 0;
        while (j < n && guard < 4000) begin
            bit wr;
            wr      = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
            w_ready = wr;
            if (offerDin) begin
                din_valid = 1'b1;
                din       = $urandom;
            end
            checkOutput("run_w_valid", 32'(oWValid), 32'd1);
            checkOutput("run_din_ready", 32'(oDinReady), 32'd0);
            checkOutput("run_busy", 32'(oBusy), 32'd1);
            checkOutput("run_done", 32'(oDone), 32'd0);
            checkOutput("run_w_idx", 32'(oWIdx), 32'(j));
            checkOutput("run_w_out", oWOut, refW[j]);
            checkOutput("run_wp_out", oWpOut, refW[j] ^ refW[j+4]);
            if (wr) begin
                gotW[j]  = oWOut;
                gotWp[j] = oWpOut;
                j++;
            end
            step();
            guard++;
        end
        w_ready   = 1'b0;
        din_valid = 1'b0;
        if (j < n) checkOutput("run_timeout", 32'(j), 32'(n));
        endCyc = cyc;
    endtask

    task automatic endOfBlock(input bit pulseCheck);
        checkOutput("done_pulse", 32'(oDone), 32'd1);
        checkOutput("done_busy", 32'(oBusy), 32'd0);
        checkOutput("done_w_valid", 32'(oWValid), 32'd0);
        checkOutput("done_din_ready", 32'(oDinReady), 32'd1);
        if (pulseCheck) begin
            step();
            checkOutput("done_width", 32'(oDone), 32'd0);
            checkOutput("idle_busy", 32'(oBusy), 32'd0);
        end
    endtask

    task automatic pulseReset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int c0;
        int e;
        rst       = 1'b1;
        din       = 32'd0;
        din_valid = 1'b0;
        w_ready   = 1'b0;

        // Reset values while rst is held
        #1;
        checkOutput("rst_din_ready", 32'(oDinReady), 32'd0);
        checkOutput("rst_w_valid", 32'(oWValid), 32'd0);
        checkOutput("rst_busy", 32'(oBusy), 32'd0);
        checkOutput("rst_done", 32'(oDone), 32'd0);
        checkOutput("rst_w_out", oWOut, 32'd0);
        checkOutput("rst_wp_out", oWpOut, 32'd0);
        checkOutput("rst_w_idx", 32'(oWIdx), 32'd0);
        step();
        rst = 1'b0;
        step();
        checkOutput("idle_din_ready", 32'(oDinReady), 32'd1);

        $display("[TB] scenario 1: abc block, full throughput");
        setAbc();
        c0 = cyc;
        applyStimulus(1'b0);
        drainPairs(64, 1'b0, 1'b0, e);
        checkOutput("abc_done_cycle", 32'(e - c0 + 1), 32'd81);
        checkOutput("abc_w0", gotW[0], 32'h61626380);
        checkOutput("abc_wp0", gotWp[0], 32'h61626380);
        checkOutput("abc_w16", gotW[16], 32'h9092E200);
        checkOutput("abc_wp12", gotWp[12], 32'h9092E200);
        endOfBlock(1'b1);

        $display("[TB] scenario 2: abc block, random w_ready");
        applyStimulus(1'b0);
        drainPairs(64, 1'b1, 1'b0, e);
        endOfBlock(1'b1);

        $display("[TB] scenario 3: gapped load, words offered during RUN");
        applyStimulus(1'b1);
        drainPairs(64, 1'b0, 1'b1, e);
        endOfBlock(1'b1);

        $display("[TB] scenario 4: reset at j=30");
        applyStimulus(1'b0);
        drainPairs(30, 1'b0, 1'b0, e);
        checkOutput("abort_idx", 32'(oWIdx), 32'd30);
        rst = 1'b1;
        #1;
        checkOutput("abort_w_valid", 32'(oWValid), 32'd0);
        checkOutput("abort_w_out", oWOut, 32'd0);
        checkOutput("abort_wp_out", oWpOut, 32'd0);
        checkOutput("abort_w_idx", 32'(oWIdx), 32'd0);
        checkOutput("abort_busy", 32'(oBusy), 32'd0);
        checkOutput("abort_din_ready", 32'(oDinReady), 32'd0);
        step();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            checkOutput("abort_no_done", 32'(oDone), 32'd0);
            checkOutput("abort_idle", 32'(oBusy), 32'd0);
        end
        setRandom();
        applyStimulus(1'b0);
        drainPairs(64, 1'b1, 1'b0, e);
        endOfBlock(1'b1);

        $display("[TB] scenario 5: back-to-back blocks");
        setRandom();
        applyStimulus(1'b0);
        drainPairs(64, 1'b0, 1'b0, e);
        endOfBlock(1'b0);
        setRandom();
        applyStimulus(1'b0);
        drainPairs(64, 1'b1, 1'b0, e);
        endOfBlock(1'b1);

        $display("[TB] scenario 6: ROUNDS=20 build");
        pulseReset();
        sel20 = 1'b1;
        setRandom();
        applyStimulus(1'b0);
        drainPairs(20, 1'b0, 1'b0, e);
        endOfBlock(1'b1);
        for (int k = 0; k < 3; k++) begin
            step();
            checkOutput("r20_idle_w_valid", 32'(oWValid), 32'd0);
            checkOutput("r20_idle_busy", 32'(oBusy), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
